// File: rtl/onchip_dma_pkg.sv
// rtl/onchip_dma_pkg.sv - shared CSR map, bit indices and FSM states for the on-chip copy DMA
package onchip_dma_pkg;

    localparam logic [1:0] CSR_SRC  = 2'd0;
    localparam logic [1:0] CSR_DST  = 2'd1;
    localparam logic [1:0] CSR_LEN  = 2'd2;
    localparam logic [1:0] CSR_CTRL = 2'd3;

    localparam int CTRL_GO       = 0;
    localparam int CTRL_DONE_CLR = 1;
    localparam int CTRL_IRQ_EN   = 2;

    localparam int STAT_BUSY      = 0;
    localparam int STAT_DONE      = 1;
    localparam int STAT_IRQ_EN    = 2;
    localparam int STAT_COUNT_LSB = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        CAP  = 2'd2,
        WR   = 2'd3
    } dma_state_t;

endpackage

// File: rtl/onchip_dma_csr.sv
// rtl/onchip_dma_csr.sv - CSR register file, GO/DONE handling and registered readback
module onchip_dma_csr
    import onchip_dma_pkg::*;
#(
    parameter int ADDR_W = 15,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        csr_address,
    input  logic              csr_read,
    input  logic              csr_write,
    input  logic [31:0]       csr_writedata,
    output logic [31:0]       csr_readdata,
    input  logic              busy,
    input  logic              done_set,
    input  logic [LEN_W-1:0]  count,
    output logic [ADDR_W-1:0] src_cfg,
    output logic [ADDR_W-1:0] dst_cfg,
    output logic [LEN_W-1:0]  len_cfg,
    output logic              go,
    output logic              irq
);

    logic        irq_en;
    logic        done;
    logic        ctrl_wr;
    logic        cfg_wr;
    logic [31:0] rd_mux;
    logic        unused_wdata;

    assign unused_wdata = ^csr_writedata[31:LEN_W];

    assign ctrl_wr = csr_write && (csr_address == CSR_CTRL);
    assign cfg_wr  = csr_write && !busy;
    assign go      = ctrl_wr && csr_writedata[CTRL_GO] && !busy;
    assign irq     = done & irq_en;

    always_comb begin
        rd_mux = '0;
        case (csr_address)
            CSR_SRC: rd_mux[ADDR_W-1:0] = src_cfg;
            CSR_DST: rd_mux[ADDR_W-1:0] = dst_cfg;
            CSR_LEN: rd_mux[LEN_W-1:0]  = len_cfg;
            default: begin
                rd_mux[STAT_BUSY]                    = busy;
                rd_mux[STAT_DONE]                    = done;
                rd_mux[STAT_IRQ_EN]                  = irq_en;
                rd_mux[STAT_COUNT_LSB +: LEN_W]      = count;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            src_cfg      <= '0;
            dst_cfg      <= '0;
            len_cfg      <= '0;
            irq_en       <= 1'b0;
            done         <= 1'b0;
            csr_readdata <= '0;
        end else begin
            if (cfg_wr && csr_address == CSR_SRC) src_cfg <= csr_writedata[ADDR_W-1:0];
            if (cfg_wr && csr_address == CSR_DST) dst_cfg <= csr_writedata[ADDR_W-1:0];
            if (cfg_wr && csr_address == CSR_LEN) len_cfg <= csr_writedata[LEN_W-1:0];
            if (ctrl_wr) irq_en <= csr_writedata[CTRL_IRQ_EN];
            // A zero-length GO completes on the same edge it is accepted.
            if (go)
                done <= (len_cfg == '0);
            else if (done_set)
                done <= 1'b1;
            else if (ctrl_wr && csr_writedata[CTRL_DONE_CLR])
                done <= 1'b0;
            if (csr_read) csr_readdata <= rd_mux;
        end
    end

endmodule

// File: rtl/onchip_mem_copy_dma.sv
// rtl/onchip_mem_copy_dma.sv - word copy engine mastering the on-chip RAM, 3 cycles per word
module onchip_mem_copy_dma
    import onchip_dma_pkg::*;
#(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        csr_address,
    input  logic              csr_read,
    input  logic              csr_write,
    input  logic [31:0]       csr_writedata,
    output logic [31:0]       csr_readdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [3:0]        mem_byteenable,
    output logic [DATA_W-1:0] mem_writedata,
    input  logic [DATA_W-1:0] mem_readdata,
    output logic              mem_clken,
    output logic              irq
);

    dma_state_t        state, state_nxt;
    logic [ADDR_W-1:0] src_q, dst_q;
    logic [LEN_W-1:0]  cnt_q;
    logic [DATA_W-1:0] data_q;
    logic [ADDR_W-1:0] src_cfg, dst_cfg;
    logic [LEN_W-1:0]  len_cfg;
    logic              go;
    logic              busy;
    logic              done_set;

    assign busy           = (state != IDLE);
    assign mem_byteenable = 4'hF;
    assign mem_clken      = 1'b1;
    assign mem_writedata  = data_q;

    onchip_dma_csr #(
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W)
    ) u_csr (
        .clk           (clk),
        .reset         (reset),
        .csr_address   (csr_address),
        .csr_read      (csr_read),
        .csr_write     (csr_write),
        .csr_writedata (csr_writedata),
        .csr_readdata  (csr_readdata),
        .busy          (busy),
        .done_set      (done_set),
        .count         (cnt_q),
        .src_cfg       (src_cfg),
        .dst_cfg       (dst_cfg),
        .len_cfg       (len_cfg),
        .go            (go),
        .irq           (irq)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            src_q  <= '0;
            dst_q  <= '0;
            cnt_q  <= '0;
            data_q <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (go && len_cfg != '0) begin
                        src_q <= src_cfg;
                        dst_q <= dst_cfg;
                        cnt_q <= len_cfg;
                    end
                end
                CAP: data_q <= mem_readdata;
                WR: begin
                    // Addresses wrap naturally at 2^ADDR_W.
                    src_q <= src_q + 1'b1;
                    dst_q <= dst_q + 1'b1;
                    cnt_q <= cnt_q - 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt      = state;
        mem_chipselect = 1'b0;
        mem_write      = 1'b0;
        mem_address    = '0;
        done_set       = 1'b0;
        case (state)
            IDLE: begin
                if (go && len_cfg != '0) state_nxt = RD;
            end
            RD: begin
                mem_chipselect = 1'b1;
                mem_address    = src_q;
                state_nxt      = CAP;
            end
            CAP: state_nxt = WR;
            WR: begin
                mem_chipselect = 1'b1;
                mem_write      = 1'b1;
                mem_address    = dst_q;
                if (cnt_q == LEN_W'(1)) begin
                    state_nxt = IDLE;
                    done_set  = 1'b1;
                end else begin
                    state_nxt = RD;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule
